// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: one shared round datapath and one key-expansion step,
// reused for NR rounds per block, with valid/ready handshakes on both the block input and the ciphertext output.
module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_pt,
  input  logic [127:0]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_ct,
  output logic [127:0]     rnd_state,
  output logic [127:0]     rnd_key,
  output logic             rnd_final,
  input  logic [127:0]     rnd_out,
  output logic [127:0]     ks_key,
  output logic [7:0]       ks_rcon,
  input  logic [127:0]     ks_next_key,
  output logic             busy,
  output logic [CNT_W-1:0] round_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   fsm;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic         last_round;

  assign last_round = (round_cnt == CNT_W'(NR));

  // Rcon is selected by round number (1-based), so round r uses RCON[r-1].
  function automatic logic [7:0] rcon_of(input logic [CNT_W-1:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    case (rnd)
      CNT_W'(1):  r = 8'h01;
      CNT_W'(2):  r = 8'h02;
      CNT_W'(3):  r = 8'h04;
      CNT_W'(4):  r = 8'h08;
      CNT_W'(5):  r = 8'h10;
      CNT_W'(6):  r = 8'h20;
      CNT_W'(7):  r = 8'h40;
      CNT_W'(8):  r = 8'h80;
      CNT_W'(9):  r = 8'h1b;
      CNT_W'(10): r = 8'h36;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm       <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          // The initial AddRoundKey is folded into the accept edge.
          if (in_valid) begin
            state_reg <= in_pt ^ in_key;
            key_reg   <= in_key;
            round_cnt <= CNT_W'(1);
            fsm       <= RUN;
          end
        end
        RUN: begin
          state_reg <= rnd_out;
          key_reg   <= ks_next_key;
          if (last_round) begin
            fsm <= DONE;
          end else begin
            round_cnt <= round_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            round_cnt <= '0;
          end
        end
        default: begin
          fsm       <= IDLE;
          round_cnt <= '0;
        end
      endcase
    end
  end

  // Datapath-facing outputs are zeroed outside RUN so idle cycles present a quiet bus.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_ct    = '0;
    rnd_state = '0;
    rnd_key   = '0;
    rnd_final = 1'b0;
    ks_key    = '0;
    ks_rcon   = '0;
    busy      = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy      = 1'b1;
        rnd_state = state_reg;
        rnd_key   = ks_next_key;
        rnd_final = last_round;
        ks_key    = key_reg;
        ks_rcon   = rcon_of(round_cnt);
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_ct    = state_reg;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
